cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, one group per pipeline stage, with a registered carry between stages. It replaces the fixed 4-bit combinational adder in datapaths that need wider operands at full clock rate. Operands and results move through valid/ready handshakes. Each stage holds one operation, so throughput is one operation per cycle when the output is not stalled.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
- NBLK, WIDTH/4, derived localparam (not overridable); number of CLA groups, which equals the number of pipeline stages
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) or borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the top bit (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- Effective B operand: b_eff = sub ? ~b : b.
- Effective carry-in: c0 = sub ? ~cin : cin. For sub, this gives a + ~b + 1 - cin.
- Group k (0..NBLK-1) covers bits [4k+3:4k].
  - Computes P = a^b_eff and G = a&b_eff.
  - Produces full lookahead carries C1..C4 from its carry-in.
  - sum bit i = P[i] ^ C[i].
- Stage k evaluates group k using the carry-out registered by stage k-1. Stage 0 uses c0.
- Operand skew:
  - Each stage carries forward the unprocessed upper slices of a and b_eff.
  - Each stage also carries the completed lower sum slices.
  - Slices already summed are not re-registered as operands.
- Final stage outputs:
  - cout = C[WIDTH].
  - ovf = C[WIDTH] ^ C[WIDTH-1], taken from the top group's internal carries.
- Per-stage valid bit travels with the data. Bubbles propagate as invalid stages.
- Global advance enable: en = !out_valid || out_ready.
  - When en=0, every stage register holds its value.
  - When en=1, every stage shifts forward, including invalid stages.
- in_ready = en && !rst. An input beat is accepted when in_valid && in_ready.
- Output registers (sum, cout, ovf, out_valid) are the last stage's registers. There is no extra output flop.

## Timing
- Reset (rst high at a rising edge):
  - All valid bits, data, and carry registers are cleared to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after.
- Latency: a beat accepted at edge t presents its result on the outputs after edge t+NBLK-1, i.e. NBLK edges counting the accept edge. WIDTH=4 gives one cycle; WIDTH=16 gives 4 cycles.
- Throughput: one beat per cycle while out_ready=1.
- Output hold: when out_valid=1 and out_ready=0, sum/cout/ovf/out_valid stay stable and in_ready=0. Nothing is dropped or duplicated.
- Draining and refilling: out_valid && out_ready together with in_valid in the same cycle is legal. The pipeline shifts, and the new beat enters stage 0.
- Bubble over a stalled output: in_valid=0 while en=1 inserts a bubble. A bubble never overwrites a stalled valid result.
- Reset mid-stream: all in-flight beats are discarded, and no partial result appears afterwards.
- Width rules:
  - Wrap-around is modulo 2^WIDTH.
  - cout and ovf are both reported independently for every operation.

## Structure
- Shared package cla_pkg holds:
  - CLA_GRP = 4 (group width).
  - A function for group P/G/carry lookahead.
  - An elaboration check that WIDTH % CLA_GRP == 0.
- Sub-module cla4_group: purely combinational 4-bit group.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], c[4:1].
  - Instantiated once per stage via generate.
- Top level owns the stage registers, the skew, the valid chain, and the handshake.

## Test plan
- WIDTH=4, exhaustive sweep of all 1024 combinations of a, b, cin and sub, streamed back-to-back with out_ready=1 → every result matches a golden model for sum, cout and ovf; one result per cycle after a 1-cycle latency.
- WIDTH=16, add 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Add 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
- WIDTH=16, subtract 0x0000-0x0001, cin=0 → sum=0xFFFF, cout=0, ovf=0. Subtract 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
- WIDTH=16, back-pressure: stream 8 random beats while out_ready follows 1,0,0,1,0,1,1,0,… → results come out in order with no loss; outputs are stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
- WIDTH=32, random beats with in_valid gaps (bubbles) → results appear 8 cycles after acceptance; out_valid is low exactly for the bubble slots.
- Reset mid-stream: with 3 beats in flight, assert rst for 1 cycle → the next cycle shows out_valid=0 and all outputs 0; no stale result appears in the following NBLK cycles; a new beat completes normally.

Source files
------------

// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined CLA adder: group width, lookahead
// function and the width legality check used at elaboration.
package cla_pkg;

    localparam int CLA_GRP = 4;

    typedef struct packed {
        logic [3:0] p;
        logic [4:0] c;   // c[0] is the group carry-in, c[4] the group carry-out
    } cla_grp_t;

    function automatic cla_grp_t cla4_lookahead(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic       ci);
        logic [3:0] p;
        logic [3:0] g;
        cla_grp_t   r;
        p      = a ^ b;
        g      = a & b;
        r.p    = p;
        r.c[0] = ci;
        r.c[1] = g[0] | (p[0] & ci);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        r.c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);
        return r;
    endfunction

    function automatic bit cla_width_ok(input int w);
        return (w >= CLA_GRP) && ((w % CLA_GRP) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group: sum bits plus all internal carries.
module cla4_group
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic [4:1] c
);
    cla_grp_t r;

    assign r = cla4_lookahead(a, b, ci);
    assign s = r.p ^ r.c[3:0];
    assign c = r.c[4:1];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one 4-bit CLA group per stage, registered carry between
// stages, operands skewed so each stage only holds the slices still to be summed.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    cla_pipe_adder_if.slave   bus
);
    localparam int NBLK = WIDTH / CLA_GRP;

    if (!cla_width_ok(WIDTH)) begin : g_width_chk
        $error("cla_pipe_adder: WIDTH must be a positive multiple of %0d", CLA_GRP);
    end

    logic             en;
    logic             acc;
    logic             c0;
    logic [WIDTH-1:0] b_eff;
    logic [NBLK-1:0]  vld_q;
    logic [NBLK:0]    vld_pipe;

    // Whole pipe moves as one: a stalled result freezes every stage, bubbles included.
    assign en           = !vld_q[NBLK-1] || bus.out_ready;
    assign bus.in_ready = en && !rst;
    assign acc          = bus.in_valid && bus.in_ready;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign c0           = bus.sub ^ bus.cin;
    assign vld_pipe     = {vld_q, acc};

    always_ff @(posedge clk) begin
        if (rst)     vld_q <= '0;
        else if (en) vld_q <= vld_pipe[NBLK-1:0];
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int LO  = k * CLA_GRP;
        localparam int REM = WIDTH - LO - CLA_GRP;

        logic [3:0]    ga;
        logic [3:0]    gb;
        logic [3:0]    gs;
        logic          gci;
        logic [4:1]    gc;
        logic [LO+3:0] sum_d;
        logic [LO+3:0] sum_q;
        logic          cy_q;
        logic          unused_c;

        if (k == 0) begin : g_src
            assign ga    = bus.a[3:0];
            assign gb    = b_eff[3:0];
            assign gci   = c0;
            assign sum_d = gs;
        end else begin : g_src
            assign ga    = g_stg[k-1].g_ops.opa_q[3:0];
            assign gb    = g_stg[k-1].g_ops.opb_q[3:0];
            assign gci   = g_stg[k-1].cy_q;
            assign sum_d = {gs, g_stg[k-1].sum_q};
        end

        cla4_group u_grp (
            .a  (ga),
            .b  (gb),
            .ci (gci),
            .s  (gs),
            .c  (gc)
        );

        // Internal group carries only matter for overflow in the top group.
        assign unused_c = ^gc[3:1];

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (en) begin
                sum_q <= sum_d;
                cy_q  <= gc[4];
            end
        end

        // Operand slices still owed to later groups; index 0 is bit LO+4.
        if (REM > 0) begin : g_ops
            logic [REM-1:0] opa_d;
            logic [REM-1:0] opb_d;
            logic [REM-1:0] opa_q;
            logic [REM-1:0] opb_q;

            if (k == 0) begin : g_fwd
                assign opa_d = bus.a[WIDTH-1:CLA_GRP];
                assign opb_d = b_eff[WIDTH-1:CLA_GRP];
            end else begin : g_fwd
                assign opa_d = g_stg[k-1].g_ops.opa_q[REM+3:4];
                assign opb_d = g_stg[k-1].g_ops.opb_q[REM+3:4];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (en) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        if (k == NBLK - 1) begin : g_tail
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = gc[4] ^ gc[3];

            always_ff @(posedge clk) begin
                if (rst)     ovf_q <= 1'b0;
                else if (en) ovf_q <= ovf_d;
            end
        end
    end

    assign bus.out_valid = vld_pipe[NBLK];
    assign bus.sum       = g_stg[NBLK-1].sum_q;
    assign bus.cout      = g_stg[NBLK-1].cy_q;
    assign bus.ovf       = g_stg[NBLK-1].g_tail.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH 4, 16 and 32 sharing clock and reset.
module tb_cla_pipe_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(4))  if4 ();
    cla_pipe_adder_if #(.WIDTH(16)) if16 ();
    cla_pipe_adder_if #(.WIDTH(32)) if32 ();

    cla_pipe_adder #(.WIDTH(4))  u_w4  (.clk(clk), .rst(rst), .bus(if4.slave));
    cla_pipe_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if16.slave));
    cla_pipe_adder #(.WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .bus(if32.slave));

    // Reference: exact integer arithmetic; returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
        longint unsigned mask, ua, ub, full;
        longint          sa, sb, r, lim;
        logic            c, o;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        if (!sub) begin
            full = ua + ub + {63'd0, cin};
            c    = ((full >> w) & 64'd1) != 64'd0;
        end else begin
            full = ua - ub - {63'd0, cin};
            c    = ua >= (ub + {63'd0, cin});
        end
        sa = longint'(ua);
        sb = longint'(ub);
        if (((ua >> (w - 1)) & 64'd1) != 64'd0) sa = sa - longint'(64'd1 << w);
        if (((ub >> (w - 1)) & 64'd1) != 64'd0) sb = sb - longint'(64'd1 << w);
        if (sub) r = sa - sb - longint'(cin);
        else     r = sa + sb + longint'(cin);
        lim = longint'(64'd1 << (w - 1));
        o   = (r >= lim) || (r < -lim);
        return {o, c, 32'(full & mask)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_w4: got v=%b s=%h c=%b o=%b rdy=%b, expected all 0",
                     if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready);
        end
        checks++;
        if ({if16.out_valid, if16.sum, if16.cout, if16.ovf, if16.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_w16: got v=%b s=%h c=%b o=%b rdy=%b, expected all 0",
                     if16.out_valid, if16.sum, if16.cout, if16.ovf, if16.in_ready);
        end
        checks++;
        if ({if32.out_valid, if32.sum, if32.cout, if32.ovf, if32.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_w32: got v=%b s=%h c=%b o=%b rdy=%b, expected all 0",
                     if32.out_valid, if32.sum, if32.cout, if32.ovf, if32.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({if4.in_ready, if16.in_ready, if32.in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 111",
                     {if4.in_ready, if16.in_ready, if32.in_ready});
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [9:0]  v;
        logic [33:0] e;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            v            = 10'(i);
            if4.a        = v[3:0];
            if4.b        = v[7:4];
            if4.cin      = v[8];
            if4.sub      = v[9];
            if4.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            e = model(4, {28'd0, v[3:0]}, {28'd0, v[7:4]}, v[8], v[9]);
            checks++;
            if (if4.out_valid !== 1'b1 || if4.sum !== e[3:0] ||
                if4.cout !== e[32] || if4.ovf !== e[33]) begin
                errors++;
                $display("FAIL w4_sweep[%0d]: got v=%b s=%h c=%b o=%b, expected v=1 s=%h c=%b o=%b",
                         i, if4.out_valid, if4.sum, if4.cout, if4.ovf, e[3:0], e[32], e[33]);
            end
        end
        if4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (if4.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w4_drain: got out_valid=%b, expected 0", if4.out_valid);
        end
    endtask

    task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo);
        @(negedge clk);
        if16.a         = a;
        if16.b         = b;
        if16.cin       = cin;
        if16.sub       = sub;
        if16.in_valid  = 1'b1;
        if16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: got out_valid=%b, expected 0", name, if16.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (if16.out_valid !== 1'b1 || if16.sum !== es || if16.cout !== ec || if16.ovf !== eo) begin
            errors++;
            $display("FAIL %s: got v=%b s=%h c=%b o=%b, expected v=1 s=%h c=%b o=%b",
                     name, if16.out_valid, if16.sum, if16.cout, if16.ovf, es, ec, eo);
        end
    endtask

    task automatic test_edges_w16();
        run16("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("sub_0_1",     16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run16("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run16("sub_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        run16("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        run16("add_grp_cy",  16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure_w16();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        bit          pat [8];
        logic [18:0] hv;
        logic [33:0] e;
        bit          held;
        int          nin, nout, cyc;
        va   = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hA5A5, 16'h7FFF, 16'h0001, 16'hC3C3};
        vb   = '{16'h4321, 16'h0001, 16'h8000, 16'hF0F0, 16'h5A5A, 16'h7FFF, 16'h0002, 16'h3C3C};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        held = 1'b0;
        hv   = '0;
        nin  = 0;
        nout = 0;
        cyc  = 0;
        while (nout < 8 && cyc < 80) begin
            @(negedge clk);
            if16.out_ready = pat[cyc % 8];
            if16.in_valid  = (nin < 8);
            if (nin < 8) begin
                if16.a   = va[nin];
                if16.b   = vb[nin];
                if16.cin = nin[0];
                if16.sub = nin[1];
            end
            #1;
            checks++;
            if (if16.in_ready !== !(if16.out_valid && !if16.out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready cyc%0d: got %b with out_valid=%b out_ready=%b",
                         cyc, if16.in_ready, if16.out_valid, if16.out_ready);
            end
            if (held) begin
                checks++;
                if ({if16.out_valid, if16.cout, if16.ovf, if16.sum} !== hv) begin
                    errors++;
                    $display("FAIL bp_hold cyc%0d: got %h, expected %h", cyc,
                             {if16.out_valid, if16.cout, if16.ovf, if16.sum}, hv);
                end
            end
            held = if16.out_valid && !if16.out_ready;
            hv   = {if16.out_valid, if16.cout, if16.ovf, if16.sum};
            if (if16.out_valid && if16.out_ready) begin
                e = model(16, {16'd0, va[nout]}, {16'd0, vb[nout]}, nout[0], nout[1]);
                checks++;
                if (if16.sum !== e[15:0] || if16.cout !== e[32] || if16.ovf !== e[33]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                             nout, if16.sum, if16.cout, if16.ovf, e[15:0], e[32], e[33]);
                end
                nout++;
            end
            if (if16.in_valid && if16.in_ready) nin++;
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (nout != 8) begin
            errors++;
            $display("FAIL bp_timeout: got %0d results, expected 8", nout);
        end
        @(negedge clk);
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_bubbles_w32();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        bit          pat [10];
        logic [33:0] e;
        logic [31:0] kk;
        logic        exp_v;
        int          k;
        va  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678,
                32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'hCAFE_F00D, 32'h0000_FFFF};
        vb  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8765_4321,
                32'h1111_1111, 32'hF0F0_F0F0, 32'h0001_0000, 32'h3501_0FF3, 32'h0000_0001};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        if32.out_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            if (c < 10) begin
                kk            = 32'(c);
                if32.in_valid = pat[c];
                if32.a        = va[c];
                if32.b        = vb[c];
                if32.cin      = kk[0];
                if32.sub      = kk[1];
            end else begin
                if32.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            k     = c - 7;
            exp_v = (k >= 0 && k < 10) ? pat[k] : 1'b0;
            checks++;
            if (if32.out_valid !== exp_v) begin
                errors++;
                $display("FAIL w32_valid cyc%0d: got %b, expected %b", c, if32.out_valid, exp_v);
            end
            if (exp_v) begin
                kk = 32'(k);
                e  = model(32, va[k], vb[k], kk[0], kk[1]);
                checks++;
                if (if32.sum !== e[31:0] || if32.cout !== e[32] || if32.ovf !== e[33]) begin
                    errors++;
                    $display("FAIL w32_beat%0d: got s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                             k, if32.sum, if32.cout, if32.ovf, e[31:0], e[32], e[33]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        if16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if16.a        = 16'hAAAA + 16'(i);
            if16.b        = 16'h5555;
            if16.cin      = 1'b0;
            if16.sub      = 1'b0;
            if16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if16.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (if16.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b, expected 0", if16.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if16.out_valid, if16.sum, if16.cout, if16.ovf} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b s=%h c=%b o=%b, expected all 0",
                     if16.out_valid, if16.sum, if16.cout, if16.ovf);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (if16.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale%0d: got out_valid=%b, expected 0", i, if16.out_valid);
            end
        end
        run16("post_reset", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        if4.in_valid   = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0; if4.sub  = 1'b0;
        if16.in_valid  = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
        if32.in_valid  = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0;
        if4.out_ready  = 1'b1;
        if16.out_ready = 1'b1;
        if32.out_ready = 1'b1;

        test_reset();
        test_exhaustive_w4();
        test_edges_w16();
        test_backpressure_w16();
        test_bubbles_w32();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
